// File: rtl/h14tx_pattern_gen.sv
// rtl/h14tx_pattern_gen.sv - video test pattern generator, fixed 2-cycle latency.
// Define H14TX_PATTERN_ANIM_EN to build the frame counter and moving-bar pattern.
module h14tx_pattern_gen #(
  parameter int BitWidth    = 11,
  parameter int BitHeight   = 10,
  parameter int Width       = 1280,
  parameter int Height      = 720,
  parameter int Depth       = 8,
  parameter int CheckerLog2 = 5
) (
  input  logic                      pixel_clk,
  input  logic                      rst,
  input  logic                      de,
  input  logic [BitWidth-1:0]       x,
  input  logic [BitHeight-1:0]      y,
  input  logic [2:0]                mode,
  input  logic [3*Depth-1:0]        solid,
  output logic [2:0][Depth-1:0]     rgb,
  output logic                      rgb_de,
  output logic [7:0]                frame_cnt
);

  localparam int BarW = (Width / 8 > 0) ? Width / 8 : 1;

  typedef enum logic [2:0] {
    MODE_SOLID = 3'd0,
    MODE_GRAD  = 3'd1,
    MODE_BARS  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_MOVE  = 3'd4
  } mode_e;

  mode_e active_mode, req_mode, eff_mode, s1_mode;

  logic frame_start, frame_end;
  logic [3:0] bar_idx, bar_idx_n;
  logic [BitWidth-1:0] bar_pos, bar_pos_n;
  logic [Depth-1:0] grad_r, grad_g;
  logic in_bar;

  logic                 s1_de;
  logic [3*Depth-1:0]   s1_solid;
  logic [Depth-1:0]     s1_grad_r, s1_grad_g;
  logic [3:0]           s1_bar;
  logic                 s1_chk;
  logic                 s1_in_bar;
  logic [2:0][Depth-1:0] pix;

  assign frame_start = de && (x == '0) && (y == '0);
  assign frame_end   = de && (x == BitWidth'(Width - 1)) && (y == BitHeight'(Height - 1));

  // Unsupported codes collapse to solid before latching, so later stages see only valid modes.
  always_comb begin
    req_mode = MODE_SOLID;
    case (mode)
      3'd1: req_mode = MODE_GRAD;
      3'd2: req_mode = MODE_BARS;
      3'd3: req_mode = MODE_CHECK;
`ifdef H14TX_PATTERN_ANIM_EN
      3'd4: req_mode = MODE_MOVE;
`endif
      default: req_mode = MODE_SOLID;
    endcase
  end

  // The frame-start pixel itself already renders with the newly requested mode.
  assign eff_mode = frame_start ? req_mode : active_mode;

  generate
    if (Depth <= BitWidth) begin : g_gx
      assign grad_r = x[BitWidth-1 -: Depth];
    end else begin : g_gx_pad
      assign grad_r = {x, {(Depth - BitWidth){1'b0}}};
    end
    if (Depth <= BitHeight) begin : g_gy
      assign grad_g = y[BitHeight-1 -: Depth];
    end else begin : g_gy_pad
      assign grad_g = {y, {(Depth - BitHeight){1'b0}}};
    end
  endgenerate

  // Bar index tracks the scan position by counting pixels; index 8 means past the last bar.
  always_comb begin
    bar_idx_n = bar_idx;
    bar_pos_n = bar_pos;
    if (x == '0) begin
      bar_idx_n = 4'd0;
      bar_pos_n = '0;
    end else if (bar_pos == BitWidth'(BarW - 1)) begin
      bar_pos_n = '0;
      if (bar_idx != 4'd8) bar_idx_n = bar_idx + 4'd1;
    end else begin
      bar_pos_n = bar_pos + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      bar_idx <= 4'd0;
      bar_pos <= '0;
    end else if (de) begin
      bar_idx <= bar_idx_n;
      bar_pos <= bar_pos_n;
    end
  end

`ifdef H14TX_PATTERN_ANIM_EN
  logic [7:0]            fc;
  logic [BitWidth:0]     bar_start, start_sum, start_next;
  logic [BitWidth+1:0]   xe, se, dist;

  // Bar origin follows 4*frame_cnt modulo Width incrementally, avoiding a divider.
  assign start_sum  = bar_start + (BitWidth+1)'(4);
  assign start_next = (start_sum >= (BitWidth+1)'(Width)) ?
                      start_sum - (BitWidth+1)'(Width) : start_sum;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      fc        <= 8'd0;
      bar_start <= '0;
    end else if (frame_end) begin
      fc        <= fc + 8'd1;
      bar_start <= (fc == 8'hFF) ? '0 : start_next;
    end
  end

  assign xe     = {2'b00, x};
  assign se     = {1'b0, bar_start};
  assign dist   = (xe >= se) ? xe - se : xe + (BitWidth+2)'(Width) - se;
  assign in_bar = (dist < (BitWidth+2)'(16));
  assign frame_cnt = fc;
`else
  assign in_bar    = 1'b0;
  assign frame_cnt = 8'd0;
`endif

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      active_mode <= MODE_SOLID;
      s1_de       <= 1'b0;
      s1_mode     <= MODE_SOLID;
      s1_solid    <= '0;
      s1_grad_r   <= '0;
      s1_grad_g   <= '0;
      s1_bar      <= 4'd0;
      s1_chk      <= 1'b0;
      s1_in_bar   <= 1'b0;
    end else begin
      if (frame_start) active_mode <= req_mode;
      s1_de     <= de;
      s1_mode   <= eff_mode;
      s1_solid  <= solid;
      s1_grad_r <= grad_r;
      s1_grad_g <= grad_g;
      s1_bar    <= bar_idx_n;
      s1_chk    <= x[CheckerLog2] ^ y[CheckerLog2];
      s1_in_bar <= in_bar;
    end
  end

  always_comb begin
    pix = '0;
    case (s1_mode)
      MODE_GRAD: begin
        pix[2] = s1_grad_r;
        pix[1] = s1_grad_g;
      end
      MODE_BARS: begin
        if (!s1_bar[3]) begin
          pix[2] = {Depth{~s1_bar[1]}};
          pix[1] = {Depth{~s1_bar[2]}};
          pix[0] = {Depth{~s1_bar[0]}};
        end
      end
      MODE_CHECK: begin
        pix = {3{{Depth{~s1_chk}}}};
      end
      MODE_MOVE: begin
        pix = {3{{Depth{s1_in_bar}}}};
      end
      default: begin
        pix = s1_solid;
      end
    endcase
    if (!s1_de) pix = '0;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      rgb    <= '0;
      rgb_de <= 1'b0;
    end else begin
      rgb    <= pix;
      rgb_de <= s1_de;
    end
  end

endmodule

// File: tb/tb_h14tx_pattern_gen.sv
// tb/tb_h14tx_pattern_gen.sv - directed self-checking bench for h14tx_pattern_gen.
module tb_h14tx_pattern_gen;

  logic             pixel_clk = 1'b0;
  logic             rst;
  logic             de;
  logic [10:0]      x;
  logic [9:0]       y;
  logic [2:0]       mode;
  logic [23:0]      solid;
  logic [2:0][7:0]  rgb;
  logic             rgb_de;
  logic [7:0]       frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_de_q  [$];
  logic [23:0] exp_rgb_q [$];
  string       tag_q     [$];
  logic [23:0] bar_tab   [8];

  h14tx_pattern_gen dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .de        (de),
    .x         (x),
    .y         (y),
    .mode      (mode),
    .solid     (solid),
    .rgb       (rgb),
    .rgb_de    (rgb_de),
    .frame_cnt (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Drive one pixel; its expected output is checked two clock edges later.
  task automatic step(input logic r, input logic d, input int xx, input int yy,
                      input logic [2:0] m, input logic ed, input logic [23:0] erg,
                      input string tag);
    logic        e_de;
    logic [23:0] e_rgb;
    string       e_tag;
    rst  = r;
    de   = d;
    x    = 11'(xx);
    y    = 10'(yy);
    mode = m;
    exp_de_q.push_back(ed);
    exp_rgb_q.push_back(erg);
    tag_q.push_back(tag);
    @(posedge pixel_clk);
    #1;
    if (exp_de_q.size() == 2) begin
      e_de  = exp_de_q.pop_front();
      e_rgb = exp_rgb_q.pop_front();
      e_tag = tag_q.pop_front();
      n_checks++;
      assert ({rgb_de, rgb} === {e_de, e_rgb}) else begin
        n_fail++;
        $error("FAIL %s: observed de=%b rgb=%h expected de=%b rgb=%h",
               e_tag, rgb_de, rgb, e_de, e_rgb);
      end
    end
  endtask

  task automatic check_fc(input logic [7:0] exp_fc, input string tag);
    n_checks++;
    assert (frame_cnt === exp_fc) else begin
      n_fail++;
      $error("FAIL %s: observed frame_cnt=%0d expected %0d", tag, frame_cnt, exp_fc);
    end
  endtask

  initial begin
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00;
    bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
    rst = 1'b1; de = 1'b0; x = '0; y = '0; mode = 3'd0;
    solid = 24'hA5C33C;

    for (int i = 0; i < 3; i++) step(1, 1, 5, 5, 3'd1, 0, 24'h0, "reset");
    check_fc(8'd0, "reset_fc");
    step(0, 1, 5, 5, 3'd1, 1, 24'hA5C33C, "release_cycle1");
    check_fc(8'd0, "release_fc");
    step(0, 1, 6, 5, 3'd1, 1, 24'hA5C33C, "first_frame_mode0");
    step(0, 0, 0, 0, 3'd1, 0, 24'h0, "de_low_no_latch");

    step(0, 1, 0, 0, 3'd1, 1, 24'h000000, "grad_origin");
    step(0, 1, 1024, 512, 3'd1, 1, 24'h808000, "grad_1024_512");
    step(0, 1, 2047, 1023, 3'd1, 1, 24'hFFFF00, "grad_max");
    step(0, 1, 100, 300, 3'd0, 1, 24'h0C4B00, "grad_mode_held");
    step(0, 0, 0, 0, 3'd0, 0, 24'h0, "grad_gap");

    step(0, 1, 0, 0, 3'd2, 1, 24'hFFFFFF, "bars_x0");
    for (int xx = 1; xx < 1280; xx++) begin
      if (xx == 200) repeat (3) step(0, 0, xx, 0, 3'd2, 0, 24'h0, "bars_de_gap");
      step(0, 1, xx, 0, (xx >= 640) ? 3'd3 : 3'd2, 1, bar_tab[xx / 160], "bars_scan");
    end
    step(0, 0, 0, 0, 3'd3, 0, 24'h0, "bars_end");

    step(0, 1, 0, 0, 3'd3, 1, 24'hFFFFFF, "chk_origin");
    step(0, 1, 32, 0, 3'd3, 1, 24'h000000, "chk_32_0");
    step(0, 1, 32, 32, 3'd0, 1, 24'hFFFFFF, "chk_32_32");
    step(0, 1, 64, 0, 3'd0, 1, 24'hFFFFFF, "chk_64_0");
    step(0, 1, 31, 40, 3'd0, 1, 24'h000000, "chk_31_40");
    step(0, 0, 0, 0, 3'd0, 0, 24'h0, "chk_end");

    solid = 24'h123456;
`ifdef H14TX_PATTERN_ANIM_EN
    step(0, 1, 0, 0, 3'd4, 1, 24'hFFFFFF, "mv_x0");
    step(0, 1, 15, 0, 3'd4, 1, 24'hFFFFFF, "mv_x15");
    step(0, 1, 16, 0, 3'd4, 1, 24'h000000, "mv_x16");
    repeat (3) step(0, 1, 1279, 719, 3'd4, 1, 24'h000000, "mv_frame_end");
    check_fc(8'd3, "fc_after_3");
    step(0, 1, 11, 5, 3'd4, 1, 24'h000000, "mv3_x11");
    step(0, 1, 12, 5, 3'd4, 1, 24'hFFFFFF, "mv3_x12");
    step(0, 1, 27, 5, 3'd4, 1, 24'hFFFFFF, "mv3_x27");
    step(0, 1, 28, 5, 3'd4, 1, 24'h000000, "mv3_x28");
    for (int i = 0; i < 253; i++) step(0, 1, 1279, 719, 3'd4, 1, 24'h000000, "mv_frame_end");
    check_fc(8'd0, "fc_wrap");
    step(0, 1, 1279, 719, 3'd4, 1, 24'h000000, "mv_frame_end");
    check_fc(8'd1, "fc_after_wrap");
`else
    step(0, 1, 0, 0, 3'd4, 1, 24'h123456, "m4_solid_origin");
    step(0, 1, 12, 0, 3'd4, 1, 24'h123456, "m4_solid_x12");
    step(0, 1, 1279, 719, 3'd4, 1, 24'h123456, "m4_solid_frame_end");
    check_fc(8'd0, "fc_tied_zero");
`endif
    step(0, 0, 0, 0, 3'd2, 0, 24'h0, "pre_reset_gap");

    step(1, 1, 5, 5, 3'd2, 0, 24'h0, "mid_reset");
    check_fc(8'd0, "mid_reset_fc");
    step(0, 1, 5, 5, 3'd2, 1, 24'h123456, "abort_release1");
    step(0, 1, 6, 5, 3'd2, 1, 24'h123456, "after_reset_mode0");
    step(0, 0, 0, 0, 3'd0, 0, 24'h0, "drain1");
    step(0, 0, 0, 0, 3'd0, 0, 24'h0, "drain2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
